// File: rtl/msg_injector_pkg.sv
// rtl/msg_injector_pkg.sv - shared FSM states, constants and flit helpers for msg_injector
package msg_injector_pkg;

  // One state per emitted header flit, plus IDLE and the payload stream.
  typedef enum logic [3:0] {
    IDLE,
    HEADER,
    SIZE,
    SERVICE,
    PROD,
    CONS,
    SRCPE,
    TIMESTAMP,
    PAYLOAD
  } state_t;

  localparam logic [31:0] SVC_MSG_DELIVERY = 32'h0000_0001;

  // Flits that follow SIZE before any payload: SERVICE, PROD, CONS, SRCPE, TIMESTAMP.
  localparam logic [31:0] HDR_FLITS = 32'd5;

  // The SIZE flit counts everything after itself.
  function automatic logic [31:0] size_flit(input logic [7:0] len);
    return HDR_FLITS + {24'h0, len};
  endfunction

endpackage

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - free-running 32-bit cycle counter used to timestamp packets
module tick_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] tick_o
);

  logic [31:0] tick_q;
  logic [31:0] tick_d;

  // Plain increment; wraps from all-ones back to zero naturally.
  always_comb begin
    tick_d = tick_q + 32'd1;
  end

  // Tick register, cleared immediately by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/msg_injector.sv
// rtl/msg_injector.sv - builds header+payload packets onto a credit link; MSG_INJECTOR_STATS_EN adds packet/stall counters
module msg_injector
  import msg_injector_pkg::*;
#(
  parameter logic [15:0] ADDRESS     = 16'h0000,
  parameter int unsigned MAX_PAYLOAD = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [15:0] req_target_i,
  input  logic [31:0] req_service_i,
  input  logic [31:0] req_prod_i,
  input  logic [31:0] req_cons_i,
  input  logic [7:0]  req_len_i,
  input  logic        pl_valid_i,
  output logic        pl_ready_o,
  input  logic [31:0] pl_data_i,
  output logic        tx_o,
  input  logic        cr_tx_i,
  output logic        eop_tx_o,
  output logic [31:0] data_tx_o,
  output logic        err_o,
  output logic [31:0] pkt_cnt_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  state_t      state_q, state_d;
  logic [15:0] target_q, target_d;
  logic [31:0] svc_q, svc_d;
  logic [31:0] prod_q, prod_d;
  logic [31:0] cons_q, cons_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  rem_q, rem_d;
  logic [31:0] ts_q, ts_d;
  logic        err_q, err_d;
  logic [31:0] tick;

  tick_counter u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // Next-state and flit outputs; every header state holds its flit until the link grants credit.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    svc_d       = svc_q;
    prod_d      = prod_q;
    cons_d      = cons_q;
    len_d       = len_q;
    rem_d       = rem_q;
    ts_d        = ts_q;
    err_d       = 1'b0;
    req_ready_o = 1'b0;
    pl_ready_o  = 1'b0;
    tx_o        = 1'b0;
    eop_tx_o    = 1'b0;
    data_tx_o   = '0;
    case (state_q)
      IDLE: begin
        req_ready_o = !rst_i;
        if (req_valid_i && !rst_i) begin
          if (req_len_i > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            target_d = req_target_i;
            svc_d    = req_service_i;
            prod_d   = req_prod_i;
            cons_d   = req_cons_i;
            len_d    = req_len_i;
            rem_d    = req_len_i;
            ts_d     = tick;
            state_d  = HEADER;
          end
        end
      end
      HEADER: begin
        tx_o      = 1'b1;
        data_tx_o = {16'h0, target_q};
        if (cr_tx_i) state_d = SIZE;
      end
      SIZE: begin
        tx_o      = 1'b1;
        data_tx_o = size_flit(len_q);
        if (cr_tx_i) state_d = SERVICE;
      end
      SERVICE: begin
        tx_o      = 1'b1;
        data_tx_o = svc_q;
        if (cr_tx_i) state_d = PROD;
      end
      PROD: begin
        tx_o      = 1'b1;
        data_tx_o = prod_q;
        if (cr_tx_i) state_d = CONS;
      end
      CONS: begin
        tx_o      = 1'b1;
        data_tx_o = cons_q;
        if (cr_tx_i) state_d = SRCPE;
      end
      SRCPE: begin
        tx_o      = 1'b1;
        data_tx_o = {16'h0, ADDRESS};
        if (cr_tx_i) state_d = TIMESTAMP;
      end
      TIMESTAMP: begin
        tx_o      = 1'b1;
        data_tx_o = ts_q;
        eop_tx_o  = (len_q == 8'd0);
        if (cr_tx_i) state_d = (len_q == 8'd0) ? IDLE : PAYLOAD;
      end
      PAYLOAD: begin
        tx_o       = pl_valid_i;
        data_tx_o  = pl_data_i;
        pl_ready_o = cr_tx_i;
        eop_tx_o   = pl_valid_i && (rem_q == 8'd1);
        if (pl_valid_i && cr_tx_i) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request fields; reset abandons any packet in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      target_q <= '0;
      svc_q    <= '0;
      prod_q   <= '0;
      cons_q   <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      ts_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      svc_q    <= svc_d;
      prod_q   <= prod_d;
      cons_q   <= cons_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      ts_q     <= ts_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef MSG_INJECTOR_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters of completed packets and credit-starved cycles.
  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (tx_o && eop_tx_o && cr_tx_i && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
    if (tx_o && !cr_tx_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pkt_cnt_o   = pkt_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign pkt_cnt_o   = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_msg_injector.sv
// tb/tb_msg_injector.sv - directed self-checking bench for msg_injector
module tb_msg_injector;
  import msg_injector_pkg::*;

  localparam logic [15:0] ADDR = 16'hA5C3;
  localparam int          MAXP = 16;
`ifdef MSG_INJECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic [15:0] req_target = '0;
  logic [31:0] req_service = '0;
  logic [31:0] req_prod = '0;
  logic [31:0] req_cons = '0;
  logic [7:0]  req_len = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready_o;
  logic [31:0] pl_data = '0;
  logic        tx_o;
  logic        cr_tx = 1'b1;
  logic        eop_tx_o;
  logic [31:0] data_tx_o;
  logic        err_o;
  logic [31:0] pkt_cnt_o;
  logic [31:0] stall_cnt_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] cyc;
  logic [31:0] exp_pkt = 0;
  logic [31:0] exp_stall = 0;

  msg_injector #(.ADDRESS(ADDR), .MAX_PAYLOAD(MAXP)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_target_i (req_target),
    .req_service_i(req_service),
    .req_prod_i   (req_prod),
    .req_cons_i   (req_cons),
    .req_len_i    (req_len),
    .pl_valid_i   (pl_valid),
    .pl_ready_o   (pl_ready_o),
    .pl_data_i    (pl_data),
    .tx_o         (tx_o),
    .cr_tx_i      (cr_tx),
    .eop_tx_o     (eop_tx_o),
    .data_tx_o    (data_tx_o),
    .err_o        (err_o),
    .pkt_cnt_o    (pkt_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference cycle count: zero in the first cycle after reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end

  task automatic issue_req(input logic [15:0] t, input logic [31:0] s, input logic [31:0] p,
                           input logic [31:0] c, input logic [7:0] l, output logic [31:0] ts);
    req_target  = t;
    req_service = s;
    req_prod    = p;
    req_cons    = c;
    req_len     = l;
    req_valid   = 1'b1;
    #1;
    ts = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (tx_o !== 1'b0 || eop_tx_o !== 1'b0 || data_tx_o !== 32'h0 || req_ready_o !== 1'b0 ||
        pl_ready_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b eop=%b data=%h rdy=%b plrdy=%b err=%b, required all 0",
               tx_o, eop_tx_o, data_tx_o, req_ready_o, pl_ready_o, err_o);
    end
    checks++;
    if (pkt_cnt_o !== 32'h0 || stall_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_counters: pkt=%0d stall=%0d, required 0 0", pkt_cnt_o, stall_cnt_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || tx_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b tx=%b, required rdy=1 tx=0", req_ready_o, tx_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] ts;
    logic [31:0] exp [0:8];
    @(negedge clk);
    cr_tx = 1'b1;
    pl_valid = 1'b1;
    pl_data = 32'hCAFE_0000;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready: got %b, required 1", req_ready_o);
    end
    issue_req(16'h0102, 32'd1, 32'd7, 32'd9, 8'd2, ts);
    exp = '{32'h0000_0102, 32'd7, 32'd1, 32'd7, 32'd9, {16'h0, ADDR}, ts, 32'hCAFE_0000, 32'hCAFE_0001};
    for (int i = 0; i < 9; i++) begin
      pl_data = (i == 8) ? 32'hCAFE_0001 : 32'hCAFE_0000;
      #1;
      checks++;
      if (tx_o !== 1'b1 || data_tx_o !== exp[i] || eop_tx_o !== (i == 8)) begin
        errors++;
        $display("FAIL basic_flit%0d: tx=%b data=%h eop=%b, required tx=1 data=%h eop=%b",
                 i, tx_o, data_tx_o, eop_tx_o, exp[i], (i == 8));
      end
      checks++;
      if (pl_ready_o !== (i >= 7) || req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL basic_ready%0d: plrdy=%b rdy=%b, required plrdy=%b rdy=0",
                 i, pl_ready_o, req_ready_o, (i >= 7));
      end
      @(negedge clk);
    end
    pl_valid = 1'b0;
    exp_pkt = exp_pkt + 1;
    #1;
    checks++;
    if (tx_o !== 1'b0 || eop_tx_o !== 1'b0 || data_tx_o !== 32'h0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: tx=%b eop=%b data=%h rdy=%b, required 0 0 0 1",
               tx_o, eop_tx_o, data_tx_o, req_ready_o);
    end
    checks++;
    if (pkt_cnt_o !== (STATS ? exp_pkt : 32'h0)) begin
      errors++;
      $display("FAIL basic_pkt_cnt: got %0d, required %0d", pkt_cnt_o, (STATS ? exp_pkt : 32'h0));
    end
  endtask

  task automatic test_len0();
    logic [31:0] ts;
    logic [31:0] exp [0:6];
    @(negedge clk);
    issue_req(16'hBEEF, SVC_MSG_DELIVERY, 32'h0000_000A, 32'h0000_000B, 8'd0, ts);
    exp = '{32'h0000_BEEF, 32'd5, 32'd1, 32'h0000_000A, 32'h0000_000B, {16'h0, ADDR}, ts};
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (tx_o !== 1'b1 || data_tx_o !== exp[i] || eop_tx_o !== (i == 6)) begin
        errors++;
        $display("FAIL len0_flit%0d: tx=%b data=%h eop=%b, required tx=1 data=%h eop=%b",
                 i, tx_o, data_tx_o, eop_tx_o, exp[i], (i == 6));
      end
      @(negedge clk);
    end
    exp_pkt = exp_pkt + 1;
    #1;
    checks++;
    if (tx_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL len0_end: tx=%b rdy=%b, required tx=0 rdy=1", tx_o, req_ready_o);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ts;
    logic [31:0] exp [0:7];
    @(negedge clk);
    pl_valid = 1'b1;
    pl_data  = 32'h0000_0055;
    issue_req(16'h0300, 32'd2, 32'd7, 32'd4, 8'd1, ts);
    exp = '{32'h0000_0300, 32'd6, 32'd2, 32'd7, 32'd4, {16'h0, ADDR}, ts, 32'h0000_0055};
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        for (int s = 0; s < 3; s++) begin
          cr_tx = 1'b0;
          #1;
          checks++;
          if (tx_o !== 1'b1 || data_tx_o !== 32'd7 || eop_tx_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: tx=%b data=%h eop=%b, required tx=1 data=00000007 eop=0",
                     s, tx_o, data_tx_o, eop_tx_o);
          end
          @(negedge clk);
        end
        cr_tx = 1'b1;
      end
      #1;
      checks++;
      if (tx_o !== 1'b1 || data_tx_o !== exp[i] || eop_tx_o !== (i == 7)) begin
        errors++;
        $display("FAIL stall_flit%0d: tx=%b data=%h eop=%b, required tx=1 data=%h eop=%b",
                 i, tx_o, data_tx_o, eop_tx_o, exp[i], (i == 7));
      end
      @(negedge clk);
    end
    pl_valid  = 1'b0;
    exp_pkt   = exp_pkt + 1;
    exp_stall = exp_stall + 3;
    #1;
    checks++;
    if (stall_cnt_o !== (STATS ? exp_stall : 32'h0) || pkt_cnt_o !== (STATS ? exp_pkt : 32'h0)) begin
      errors++;
      $display("FAIL stall_counters: stall=%0d pkt=%0d, required stall=%0d pkt=%0d", stall_cnt_o,
               pkt_cnt_o, (STATS ? exp_stall : 32'h0), (STATS ? exp_pkt : 32'h0));
    end
  endtask

  task automatic test_reject();
    logic [31:0] ts;
    @(negedge clk);
    issue_req(16'h0404, 32'd1, 32'd1, 32'd1, 8'(MAXP + 1), ts);
    #1;
    checks++;
    if (err_o !== 1'b1 || tx_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reject_pulse: err=%b tx=%b rdy=%b, required err=1 tx=0 rdy=1",
               err_o, tx_o, req_ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (err_o !== 1'b0 || tx_o !== 1'b0 || req_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL reject_after%0d: err=%b tx=%b rdy=%b, required err=0 tx=0 rdy=1",
                 i, err_o, tx_o, req_ready_o);
      end
    end
  endtask

  task automatic test_gap();
    logic [31:0] ts;
    logic [31:0] w [0:2];
    int k;
    logic gap;
    w = '{32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
    @(negedge clk);
    pl_valid = 1'b0;
    issue_req(16'h0505, 32'd3, 32'd5, 32'd6, 8'd3, ts);
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (tx_o !== 1'b1 || (i == 6 && data_tx_o !== ts)) begin
        errors++;
        $display("FAIL gap_header%0d: tx=%b data=%h, required tx=1", i, tx_o, data_tx_o);
      end
      @(negedge clk);
    end
    k = 0;
    for (int s = 0; s < 5; s++) begin
      gap      = (s == 1 || s == 2);
      pl_valid = !gap;
      pl_data  = w[k];
      #1;
      checks++;
      if (tx_o !== !gap || (!gap && (data_tx_o !== w[k] || eop_tx_o !== (k == 2)))) begin
        errors++;
        $display("FAIL gap_step%0d: tx=%b data=%h eop=%b, required tx=%b data=%h eop=%b",
                 s, tx_o, data_tx_o, eop_tx_o, !gap, w[k], (k == 2));
      end
      @(negedge clk);
      if (!gap) k++;
    end
    pl_valid = 1'b0;
    exp_pkt  = exp_pkt + 1;
    #1;
    checks++;
    if (tx_o !== 1'b0 || req_ready_o !== 1'b1 || pkt_cnt_o !== (STATS ? exp_pkt : 32'h0)) begin
      errors++;
      $display("FAIL gap_end: tx=%b rdy=%b pkt=%0d, required tx=0 rdy=1 pkt=%0d",
               tx_o, req_ready_o, pkt_cnt_o, (STATS ? exp_pkt : 32'h0));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ts;
    logic [31:0] exp [0:6];
    @(negedge clk);
    pl_valid = 1'b0;
    issue_req(16'h0606, 32'd1, 32'd2, 32'd3, 8'd2, ts);
    repeat (7) @(negedge clk);
    pl_valid = 1'b1;
    pl_data  = 32'h1234_5678;
    #1;
    checks++;
    if (tx_o !== 1'b1 || data_tx_o !== 32'h1234_5678 || pl_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_payload: tx=%b data=%h plrdy=%b, required 1 12345678 1",
               tx_o, data_tx_o, pl_ready_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_o !== 1'b0 || eop_tx_o !== 1'b0 || data_tx_o !== 32'h0 || pl_ready_o !== 1'b0 ||
        req_ready_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: tx=%b eop=%b data=%h plrdy=%b rdy=%b err=%b, required all 0",
               tx_o, eop_tx_o, data_tx_o, pl_ready_o, req_ready_o, err_o);
    end
    checks++;
    if (pkt_cnt_o !== 32'h0 || stall_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_counters: pkt=%0d stall=%0d, required 0 0", pkt_cnt_o, stall_cnt_o);
    end
    exp_pkt   = 0;
    exp_stall = 0;
    @(negedge clk);
    rst      = 1'b0;
    pl_valid = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || tx_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: rdy=%b tx=%b, required rdy=1 tx=0", req_ready_o, tx_o);
    end
    issue_req(16'h0F0F, 32'd8, 32'd9, 32'd10, 8'd0, ts);
    exp = '{32'h0000_0F0F, 32'd5, 32'd8, 32'd9, 32'd10, {16'h0, ADDR}, 32'd0};
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (tx_o !== 1'b1 || data_tx_o !== exp[i] || eop_tx_o !== (i == 6)) begin
        errors++;
        $display("FAIL rstmid_flit%0d: tx=%b data=%h eop=%b, required tx=1 data=%h eop=%b",
                 i, tx_o, data_tx_o, eop_tx_o, exp[i], (i == 6));
      end
      @(negedge clk);
    end
    exp_pkt = exp_pkt + 1;
    #1;
    checks++;
    if (pkt_cnt_o !== (STATS ? exp_pkt : 32'h0) || tx_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_end: pkt=%0d tx=%b, required pkt=%0d tx=0",
               pkt_cnt_o, tx_o, (STATS ? exp_pkt : 32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_reject();
    test_gap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/msg_injector.md
MSG_INJECTOR -- requirements
Module: msg_injector

Interface
REQ-001 SHALL have parameter ADDRESS, default 16'h0000, meaning the local router address, placed in the SRCPE flit.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 16, meaning the maximum payload words per packet (1..255).
REQ-003 SHALL have ports:
- clk_i  in  1  clock; one clock only.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  message request valid.
- req_ready_o  out  1  request accepted when both high.
- req_target_i  in  16  destination address; becomes the HEADER flit.
- req_service_i  in  32  service code.
- req_prod_i  in  32  producer id.
- req_cons_i  in  32  consumer id.
- req_len_i  in  8  payload word count.
- pl_valid_i  in  1  payload word valid.
- pl_ready_o  out  1  payload word consumed.
- pl_data_i  in  32  payload word.
- tx_o  out  1  flit valid.
- cr_tx_i  in  1  link credit.
- eop_tx_o  out  1  last flit of packet.
- data_tx_o  out  32  flit data.
- err_o  out  1  one-cycle pulse on a rejected request.
- pkt_cnt_o  out  32  packets sent.
- stall_cnt_o  out  32  cycles with tx_o=1 and cr_tx_i=0.

Function
REQ-004 A flit SHALL transfer only in a cycle where tx_o=1 and cr_tx_i=1; data_tx_o and eop_tx_o SHALL hold stable while tx_o=1 and cr_tx_i=0.
REQ-005 The FSM SHALL have states IDLE, HEADER, SIZE, SERVICE, PROD, CONS, SRCPE, TIMESTAMP, PAYLOAD.
REQ-006 Each state from HEADER to TIMESTAMP SHALL advance on a transfer; otherwise it SHALL hold.
REQ-007 Flit contents SHALL be:
- HEADER = {16'h0, target}.
- SIZE = 5 + len, zero-extended to 32 bits.
- SERVICE, PROD, CONS = the values latched at acceptance.
- SRCPE = {16'h0, ADDRESS}.
- TIMESTAMP = the tick counter value latched at acceptance.
REQ-008 req_ready_o SHALL be 1 only in IDLE while rst_i=0; acceptance latches all req_* fields and the tick counter value.
REQ-009 Acceptance in cycle N SHALL present the HEADER flit (tx_o=1) in cycle N+1.
REQ-010 A request with req_len_i > MAX_PAYLOAD SHALL be rejected:
- err_o pulses for one cycle.
- The FSM stays in IDLE.
- No flit is emitted.
REQ-011 In PAYLOAD, the block SHALL behave as follows:
- tx_o = pl_valid_i.
- data_tx_o = pl_data_i.
- pl_ready_o = cr_tx_i.
- Each transfer decrements the remaining count.
- pl_ready_o SHALL be 0 in all other states.
REQ-012 eop_tx_o SHALL be 1 on the last flit: the TIMESTAMP flit when len=0, otherwise the final PAYLOAD word.
REQ-013 A transfer with eop_tx_o=1 SHALL return the FSM to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-014 The tick counter SHALL be 32 bits, increment every cycle from 0 after reset, and wrap 0xFFFFFFFF -> 0.
REQ-015 In IDLE, tx_o SHALL be 0, eop_tx_o SHALL be 0, and data_tx_o SHALL be 0.

Reset
REQ-016 Asserting rst_i SHALL immediately clear the following: state=IDLE, tx_o=0, eop_tx_o=0, data_tx_o=0, req_ready_o=0, pl_ready_o=0, err_o=0, tick=0, both counters=0.
REQ-017 Reset mid-packet SHALL abandon the packet with no EOP flit; the first cycle after release SHALL be IDLE with req_ready_o=1.

Configuration
REQ-018 With MSG_INJECTOR_STATS_EN defined, pkt_cnt_o SHALL increment on each EOP transfer and stall_cnt_o SHALL increment on each stalled cycle; both saturate at 0xFFFFFFFF.
REQ-019 Without MSG_INJECTOR_STATS_EN, both counter outputs SHALL be constant 0 and no counter registers SHALL exist.

Structure
REQ-020 Package msg_injector_pkg SHALL hold:
- the FSM state enum.
- service constant SVC_MSG_DELIVERY = 32'h00000001.
- constant HDR_FLITS = 5 (flits after SIZE, excluding payload).
REQ-021 The tick counter SHALL be a sub-module, tick_counter: 32-bit, async active-high reset, with output tick_o.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Request target=16'h0102, svc=1, prod=7, cons=9, len=2, with credit held high -> cycles N+1..N+9 carry 0x0102, 7, 1, 7, 9, ADDRESS, ts, p0, p1; eop_tx_o=1 only on p1.
- len=0 -> packet is 7 flits; eop_tx_o=1 on TIMESTAMP; SIZE=5.
- cr_tx_i=0 for 3 cycles during PROD -> flit stays 7 for the whole stall; stall_cnt_o += 3 with MSG_INJECTOR_STATS_EN.
- req_len_i=MAX_PAYLOAD+1 -> err_o high for 1 cycle; tx_o stays 0; req_ready_o stays 1.
- rst_i asserted during PAYLOAD -> tx_o=0 in the same cycle; after release, a new request emits a fresh HEADER with TIMESTAMP near 0.
- pl_valid_i=0 for 2 cycles mid-payload -> tx_o=0 for those cycles; no word is skipped or duplicated.
